// File: rtl/mips_mem_responder.sv
// Wait-state memory responder for the multicycle MIPS control path: IDLE -> WAIT -> RESP.
// Optional address checking is enabled by defining MEM_RESP_ERR_EN.
module mips_mem_responder #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned Depth    = 2 ** ADDR_WIDTH;
  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0]   mem_q [Depth];

  logic                    req_err;
  logic                    mem_we;
  logic                    load_rd;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    rd_we;
  logic                    rd_err;

`ifdef MEM_RESP_ERR_EN
  logic [31:0] addr_hi;
  assign addr_hi = addr_i >> (ADDR_WIDTH + 2);
  assign req_err = (addr_i[1:0] != 2'b00) || (addr_hi != '0);
`else
  // Byte-offset and out-of-range bits are dropped so the index wraps modulo depth.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};
  assign req_err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    load_rd = 1'b0;
    rd_idx  = idx_q;
    rd_we   = we_q;
    rd_err  = err_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          idx_d   = addr_i[ADDR_WIDTH+1:2];
          we_d    = we_i;
          err_d   = req_err;
          wdata_d = wdata_i;
          if (WaitInit == 4'd0) begin
            // Zero wait states: RESP is entered at the accepting edge, so use live inputs.
            state_d = StResp;
            load_rd = 1'b1;
            rd_idx  = addr_i[ADDR_WIDTH+1:2];
            rd_we   = we_i;
            rd_err  = req_err;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StResp;
          cnt_d   = 4'd0;
          load_rd = 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
        mem_we  = we_q && !err_q;
      end
      default: state_d = StIdle;
    endcase

    if (load_rd && !rd_we && !rd_err) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array contents survive reset; an aborted write never reaches RESP.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign rdata_o = rdata_q;
  assign ready_o = (state_q == StResp);
  assign busy_o  = (state_q != StIdle);
  assign err_o   = (state_q == StResp) && err_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder: default instance (2 wait states) and a zero-wait instance.
module tb_mips_mem_responder;

  logic        clk;
  logic        rst;
  logic        req, req0, we;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, rdata0;
  logic        ready, busy, err;
  logic        ready0, busy0, err0;

  int checks = 0;
  int errors = 0;

  mips_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata),
    .ready_o (ready),
    .busy_o  (busy),
    .err_o   (err)
  );

  mips_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req0),
    .we_i    (we),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata0),
    .ready_o (ready0),
    .busy_o  (busy0),
    .err_o   (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the default instance; a_late/d_late are applied while busy.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] a_late, input logic [31:0] d_late,
                     output logic [31:0] rd, output logic e, output int n);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    step();
    req   = 1'b0;
    addr  = a_late;
    wdata = d_late;
    check("busy_after_req", {31'd0, busy}, 32'd1);
    n = 0;
    while (!ready && n < 20) begin
      step();
      n++;
    end
    rd = rdata;
    e  = err;
    step();
    check("ready_one_cycle", {31'd0, ready}, 32'd0);
    check("idle_after_resp", {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] rd;
  logic        e;
  int          n;

  initial begin
    rst   = 1'b0;
    req   = 1'b1;
    req0  = 1'b0;
    we    = 1'b1;
    addr  = 32'h10;
    wdata = 32'hFFFF_FFFF;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_busy0", {31'd0, busy0}, 32'd0);
    rst = 1'b1;

    // Write then read at default parameters; first req accepted on the first edge.
    txn(1'b1, 32'h10, 32'hA5A5_1234, 32'h10, 32'hA5A5_1234, rd, e, n);
    check("wr10_latency", n, 32'd2);
    check("wr10_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 32'h10, 32'h0, rd, e, n);
    check("rd10_latency", n, 32'd2);
    check("rd10_data", rd, 32'hA5A5_1234);
    check("rd10_err", {31'd0, e}, 32'd0);

    txn(1'b1, 32'h0, 32'h0000_0C0C, 32'h0, 32'h0000_0C0C, rd, e, n);
    txn(1'b1, 32'h20, 32'h2020_2020, 32'h20, 32'h2020_2020, rd, e, n);
    check("rdata_held_on_write", rd, 32'hA5A5_1234);

    // Address and data changes during WAIT must be ignored.
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h20, 32'h0BAD_0BAD, rd, e, n);
    txn(1'b0, 32'h10, 32'h0, 32'h10, 32'h0, rd, e, n);
    check("ignored_rd10", rd, 32'hDEAD_BEEF);
    txn(1'b0, 32'h20, 32'h0, 32'h20, 32'h0, rd, e, n);
    check("ignored_rd20", rd, 32'h2020_2020);

    // Reset in WAIT aborts a write.
    txn(1'b1, 32'h8, 32'h0808_0808, 32'h8, 32'h0808_0808, rd, e, n);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h8;
    wdata = 32'hFFFF_FFFF;
    step();
    req = 1'b0;
    step();
    check("abort_in_wait", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rdata", rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort_no_ready", {31'd0, ready}, 32'd0);
    end
    rst = 1'b1;
    txn(1'b0, 32'h8, 32'h0, 32'h8, 32'h0, rd, e, n);
    check("abort_mem8", rd, 32'h0808_0808);

`ifdef MEM_RESP_ERR_EN
    txn(1'b1, 32'h13, 32'h1313_1313, 32'h13, 32'h1313_1313, rd, e, n);
    check("err13_latency", n, 32'd2);
    check("err13_err", {31'd0, e}, 32'd1);
    txn(1'b0, 32'h401, 32'h0, 32'h401, 32'h0, rd, e, n);
    check("err_rd_err", {31'd0, e}, 32'd1);
    check("err_rd_rdata", rd, 32'h0808_0808);
    txn(1'b0, 32'h10, 32'h0, 32'h10, 32'h0, rd, e, n);
    check("err13_nowrite", rd, 32'hDEAD_BEEF);
    txn(1'b1, 32'h400, 32'h1111_1111, 32'h400, 32'h1111_1111, rd, e, n);
    check("err400_err", {31'd0, e}, 32'd1);
    txn(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rd, e, n);
    check("err400_nowrite", rd, 32'h0000_0C0C);
    check("rd0_err", {31'd0, e}, 32'd0);
`else
    txn(1'b1, 32'h400, 32'h1111_1111, 32'h400, 32'h1111_1111, rd, e, n);
    check("wr400_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rd, e, n);
    check("wrap_rd0", rd, 32'h1111_1111);
    check("wrap_rd0_err", {31'd0, e}, 32'd0);
`endif

    // Zero wait states: back-to-back write then read of the same word.
    req0  = 1'b1;
    we    = 1'b1;
    addr  = 32'h4;
    wdata = 32'h0000_0044;
    step();
    check("w0_wr_ready", {31'd0, ready0}, 32'd1);
    we    = 1'b0;
    wdata = 32'h0;
    step();
    check("w0_idle_ready", {31'd0, ready0}, 32'd0);
    check("w0_idle_busy", {31'd0, busy0}, 32'd0);
    step();
    check("w0_rd_ready", {31'd0, ready0}, 32'd1);
    check("w0_rd_data", rdata0, 32'h0000_0044);
    addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("w0_hold_idle_busy", {31'd0, busy0}, 32'd0);
      check("w0_hold_idle_ready", {31'd0, ready0}, 32'd0);
      step();
      check("w0_hold_resp_busy", {31'd0, busy0}, 32'd1);
      check("w0_hold_resp_ready", {31'd0, ready0}, 32'd1);
      check("w0_hold_err", {31'd0, err0}, 32'd0);
    end
    req0 = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
